// File: rtl/imm_encode_unit.sv
// imm_encode_unit: scatters a 32-bit immediate into the RISC-V immediate
// fields of a base instruction word (I/S/B/J/U), flags values that do not
// fit the field, and queues {err, instr} in a DEPTH-entry FIFO.
//
// Build option: define IMM_ENC_ERR_DROP_EN to discard erroneous items at the
// input (they still complete the handshake and are counted) and expose a
// sticky err_sticky flag instead of queueing them.
//
// Handshake: an input item transfers on a rising edge where in_valid &&
// in_ready; the FIFO head transfers where out_valid && out_ready. in_ready
// depends only on FIFO fullness and out_valid only on FIFO emptiness, so
// neither ready nor valid depends combinationally on the other side; a
// producer must hold its item stable until it transfers.
module imm_encode_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             err_out,
`ifdef IMM_ENC_ERR_DROP_EN
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] enc_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;

  // Immediate scatter and range check for the item on the input side.
  always_comb begin
    enc_instr = base;
    enc_err   = 1'b0;
    case (ImmSrc)
      SRC_I: begin
        enc_instr[31:20] = imm[11:0];
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SRC_S: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SRC_B: begin
        enc_instr[31]    = imm[12];
        enc_instr[7]     = imm[11];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        enc_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      SRC_J: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
        enc_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      SRC_U: begin
        enc_instr[31:12] = imm[31:12];
        enc_err = |imm[11:0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // Occupancy flags from wrap-bit pointers, and the transfer strobes.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    in_ready  = !full;
    out_valid = !empty;
    accept    = in_valid && in_ready;
`ifdef IMM_ENC_ERR_DROP_EN
    push      = accept && !enc_err;
`else
    push      = accept;
`endif
    pop       = out_valid && out_ready;
  end

  // Head outputs read registered storage; forced to zero while empty.
  always_comb begin
    instr_out = 32'd0;
    err_out   = 1'b0;
    if (!empty) begin
      instr_out = mem[rd_ptr[AW-1:0]][31:0];
      err_out   = mem[rd_ptr[AW-1:0]][32];
    end
  end

  // FIFO storage; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {enc_err, enc_instr};
    end
  end

  // Pointers and accept counter; reset flushes everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      enc_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (accept) enc_count <= enc_count + CNT_W'(1);
    end
  end

`ifdef IMM_ENC_ERR_DROP_EN
  // Sticky record that at least one erroneous item was discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (accept && enc_err) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encode_unit.sv
// Testbench for imm_encode_unit: directed steps plus a randomized phase,
// checked every cycle against a queue-based reference of the FIFO contents.
module tb_imm_encode_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_src;
  logic [31:0]      imm;
  logic [31:0]      base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr_out;
  logic             err_out;
  logic [CNT_W-1:0] enc_count;
`ifdef IMM_ENC_ERR_DROP_EN
  logic             err_sticky;
  localparam bit    DROP = 1'b1;
`else
  localparam bit    DROP = 1'b0;
`endif

  imm_encode_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (imm_src),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .err_out   (err_out),
`ifdef IMM_ENC_ERR_DROP_EN
    .err_sticky(err_sticky),
`endif
    .enc_count (enc_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [32:0] exp_q[$];
  int          exp_cnt;
  bit          exp_sticky;
  int          n_cmp;
  int          n_fail;

  // Reference encoder built from field masks and shifts.
  function automatic logic [31:0] ref_instr(input logic [2:0] s, input logic [31:0] i,
                                            input logic [31:0] b);
    case (s)
      3'd0: return (b & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
      3'd1: return (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
      3'd2: return (b & 32'h01FF_F07F) | (((i >> 12) & 1) << 31) | (((i >> 11) & 1) << 7)
                 | (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8);
      3'd3: return (b & 32'h0000_0FFF) | (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                 | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
      3'd4: return (b & 32'h0000_0FFF) | (i & 32'hFFFF_F000);
      default: return b;
    endcase
  endfunction

  // Reference range check using signed integer bounds.
  function automatic bit ref_err(input logic [2:0] s, input logic [31:0] i);
    longint v;
    v = longint'($signed(i));
    case (s)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (v < -4096) || (v > 4095) || i[0];
      3'd3:       return (v < -(64'sd1 << 20)) || (v >= (64'sd1 << 20)) || i[0];
      3'd4:       return (i % 4096) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: predict the edge, advance, then compare on the falling edge.
  task automatic step();
    bit          acc;
    bit          pop;
    bit          e;
    logic [31:0] w;
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() > 0);
    e   = ref_err(imm_src, imm);
    w   = ref_instr(imm_src, imm, base);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt    = 0;
      exp_sticky = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_cnt++;
        if (DROP && e) exp_sticky = 1'b1;
        else           exp_q.push_back({e, w});
      end
    end
    @(negedge clk);
    check("in_ready",  32'(in_ready),  32'(exp_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("instr_out", instr_out, (exp_q.size() > 0) ? exp_q[0][31:0] : 32'd0);
    check("err_out",   32'(err_out),   (exp_q.size() > 0) ? 32'(exp_q[0][32]) : 32'd0);
    check("enc_count", 32'(enc_count), 32'(exp_cnt[CNT_W-1:0]));
`ifdef IMM_ENC_ERR_DROP_EN
    check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
`endif
  endtask

  task automatic push_one(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    imm_src  = s;
    imm      = i;
    base     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Random item; legal=1 restricts to in-range immediates of valid types.
  task automatic drive_random(input bit legal);
    logic [2:0] s;
    s = legal ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
    imm_src = s;
    base    = $urandom;
    if (!legal && $urandom_range(0, 3) == 0) begin
      imm = $urandom;
    end else begin
      case (s)
        3'd0, 3'd1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        3'd3:       imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        default:    imm = $urandom & 32'hFFFF_F000;
      endcase
    end
  endtask

  initial begin
    int start_cnt;
    n_cmp = 0; n_fail = 0;
    exp_cnt = 0; exp_sticky = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 3'd0; imm = 32'd0; base = 32'd0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_count", 32'(enc_count), 32'd0);

    // Type coverage, head visible one cycle after accept
    out_ready = 1'b1;
    push_one(3'd0, 32'd5, 32'h0000_0093);
    check("tp_i", instr_out, 32'h0050_0093);
    check("tp_i_err", 32'(err_out), 32'd0);
    step();
    push_one(3'd1, 32'd8, 32'h0020_A023);
    check("tp_s", instr_out, 32'h0020_A423);
    step();
    push_one(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    check("tp_b", instr_out, 32'hFE00_0EE3);
    step();
    push_one(3'd3, 32'h0000_0800, 32'h0000_00EF);
    check("tp_j", instr_out, 32'h0010_00EF);
    step();
    push_one(3'd4, 32'h1234_5000, 32'h0000_02B7);
    check("tp_u", instr_out, 32'h1234_52B7);
    step();

    // Range and type errors
    push_one(3'd0, 32'd2048, 32'h0000_0013);
`ifdef IMM_ENC_ERR_DROP_EN
    check("drop_i_valid", 32'(out_valid), 32'd0);
    check("drop_i_sticky", 32'(err_sticky), 32'd1);
`else
    check("err_i", 32'(err_out), 32'd1);
    check("err_i_field", 32'(instr_out[31:20]), 32'h800);
`endif
    step();
    push_one(3'd2, 32'd3, 32'h0000_0063);
`ifdef IMM_ENC_ERR_DROP_EN
    check("drop_b_valid", 32'(out_valid), 32'd0);
`else
    check("err_b", 32'(err_out), 32'd1);
`endif
    step();
    push_one(3'd6, 32'd0, 32'h1234_5678);
`ifdef IMM_ENC_ERR_DROP_EN
    check("drop_t_valid", 32'(out_valid), 32'd0);
    check("drop_t_sticky", 32'(err_sticky), 32'd1);
`else
    check("err_type", 32'(err_out), 32'd1);
    check("err_type_base", instr_out, 32'h1234_5678);
`endif
    step();

    // Backpressure: fill, hold off a fifth, then drain
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_random(1'b1);
      in_valid = 1'b1;
      step();
    end
    check("bp_full", 32'(in_ready), 32'd0);
    drive_random(1'b1);
    for (int k = 0; k < 3; k++) step();
    check("bp_held_cnt", 32'(enc_count), 32'(exp_cnt[CNT_W-1:0]));
    out_ready = 1'b1;
    step();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Concurrent push/pop at occupancy 2
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_random(1'b1);
      in_valid = 1'b1;
      step();
    end
    start_cnt = exp_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_random(1'b1);
      step();
      check("cc_occ_valid", 32'(out_valid), 32'd1);
    end
    check("cc_count", 32'(enc_count), 32'((start_cnt + 10) % 65536));
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();

    // Reset with three items queued; handshake in the reset cycle is ignored
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_random(1'b1);
      in_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_count", 32'(enc_count), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    push_one(3'd0, 32'h0000_07FF, 32'h0000_0013);
    check("mr_first", instr_out, 32'h7FF0_0013);
    out_ready = 1'b1;
    step();

    // Randomized traffic including errors
    for (int k = 0; k < 400; k++) begin
      drive_random(1'b0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encode_unit.md
Name: imm_encode_unit

Overview:
Inverse of the immediate extender. Takes a 32-bit immediate, an ImmSrc type code (same encoding the extender uses) and a base instruction word holding the non-immediate fields. It scatters the immediate into the RISC-V bit positions for that type, range-checks it, and queues the resulting instruction word in a small FIFO. The output side uses a valid/ready handshake. Used by the test-program loader and the self-check path to assemble instructions for instruction memory.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 16, width of enc_count

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input item present
in_ready  output  1  unit can accept an item this cycle
ImmSrc  input  3  0=I, 1=S, 2=B, 3=J, 4=U, 5-7 invalid
imm  input  32  immediate value, byte offset for B/J
base  input  32  instruction word with opcode, rd, rs1, rs2, funct fields; immediate bit positions are ignored
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes the head
instr_out  output  32  encoded instruction at the FIFO head
err_out  output  1  range/type error flag for the head item
enc_count  output  CNT_W  number of items accepted since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset values: in_ready=1, out_valid=0, instr_out=0, err_out=0, enc_count=0, FIFO empty with pointers at 0.
- Reset mid-operation: the FIFO is flushed and all queued items are lost. Any handshake in the reset cycle is ignored.
- Accept rule: an item is accepted when in_valid && in_ready. in_ready = !full. There is no pass-through when full, even if out_ready=1 in the same cycle.
- Pop rule: the head is popped when out_valid && out_ready. out_valid = !empty.
- Latency: an item accepted at edge N appears at the head (if the FIFO was empty) immediately after edge N, so out_valid is high in cycle N+1. instr_out and err_out come from registered FIFO storage; there is no combinational input-to-output path.
- Simultaneous push and pop when neither full nor empty: both happen and occupancy is unchanged.
- Push and pop when empty: only the push happens.
- Pointers wrap modulo DEPTH. Full/empty are detected with an extra wrap bit.
- Encoding: instr = base with the immediate fields overwritten as follows.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
  - Invalid ImmSrc: instr = base unchanged
- Error flag, stored per entry:
  - I/S: imm[31:11] is not all-equal (value does not fit signed 12 bits)
  - B: imm[31:12] is not all-equal, or imm[0]=1
  - J: imm[31:20] is not all-equal, or imm[0]=1
  - U: imm[11:0] != 0
  - ImmSrc 5-7: always an error
  - An erroneous item is still encoded, using truncated bits.
- enc_count increments on every accept, including erroneous items, and wraps from all-ones to 0.

Optional Feature:
Macro IMM_ENC_ERR_DROP_EN.
- When defined: erroneous items are accepted (in_ready handshake completes) and enc_count increments, but the item is not pushed into the FIFO. err_out is then always 0 at the head. An extra output port err_sticky (1 bit, reset 0) is set on any dropped item and cleared only by rst.
- When undefined: all items are queued as described above and the err_sticky port does not exist.

Test Plan:
- Type coverage, out_ready=1: ImmSrc=0, base=0x00000093, imm=5 -> instr_out=0x00500093, err_out=0, one cycle after accept.
- Type coverage, remaining types:
  - ImmSrc=1, base=0x0020A023, imm=8 -> 0x0020A423
  - ImmSrc=2, base=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3
  - ImmSrc=3, base=0x000000EF, imm=0x800 -> 0x001000EF
  - ImmSrc=4, base=0x000002B7, imm=0x12345000 -> 0x123452B7
- Range errors:
  - ImmSrc=0, imm=2048 -> err_out=1, instr_out[31:20]=0x800
  - ImmSrc=2, imm=3 -> err_out=1
  - ImmSrc=6 -> err_out=1, instr_out=base
  - Repeat with IMM_ENC_ERR_DROP_EN -> nothing is queued, err_sticky=1.
- Backpressure, DEPTH=4, out_ready=0: push 4 items -> in_ready=0 after the 4th accept; a 5th in_valid is held off. Raise out_ready -> items drain in order, one per cycle, and in_ready returns to 1 after the first pop.
- Concurrent push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, order is preserved, enc_count increases by 10.
- Reset with 3 items queued: assert rst for 1 cycle -> out_valid=0, enc_count=0, in_ready=1, and the next accepted item is the first one output.
